// File: rtl/spike_sched.sv
// Spike event scheduler: two requesters share a circular FIFO through a
// round-robin arbiter; entries are popped one at a time into the AER output block.
module spike_sched #(
    parameter int M     = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          NEUR_SPK_VLD,
    input  logic [M-1:0]  NEUR_SPK_ADDR,
    output logic          NEUR_SPK_RDY,
    input  logic          EXT_SPK_VLD,
    input  logic [M-1:0]  EXT_SPK_ADDR,
    output logic          EXT_SPK_RDY,
    input  logic          AEROUT_CTRL_BUSY,
    output logic          CTRL_AEROUT_POP_NEUR,
    output logic [M-1:0]  SCHED_DATA_OUT,
    output logic          SCHED_EMPTY,
    output logic          SCHED_FULL,
    output logic [CW-1:0] SCHED_COUNT
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, POP, WAIT_ACC, WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_ext_q, last_ext_d;
    logic [M-1:0]  mem_q [DEPTH];

    logic         full, push, pop;
    logic [M-1:0] push_addr;

    // On a tie the requester that did not win last time is granted.
    assign full         = (count_q == CW'(DEPTH));
    assign NEUR_SPK_RDY = !full && NEUR_SPK_VLD && (!EXT_SPK_VLD || last_ext_q);
    assign EXT_SPK_RDY  = !full && EXT_SPK_VLD && (!NEUR_SPK_VLD || !last_ext_q);
    assign push         = NEUR_SPK_RDY || EXT_SPK_RDY;
    assign push_addr    = NEUR_SPK_RDY ? NEUR_SPK_ADDR : EXT_SPK_ADDR;
    assign pop          = (state_q == POP);

    assign CTRL_AEROUT_POP_NEUR = pop;
    assign SCHED_DATA_OUT       = pop ? mem_q[rd_ptr_q] : '0;
    assign SCHED_EMPTY          = (count_q == '0);
    assign SCHED_FULL           = full;
    assign SCHED_COUNT          = count_q;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        last_ext_d = push ? EXT_SPK_RDY : last_ext_q;
        count_d    = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (count_q != '0 && !AEROUT_CTRL_BUSY) state_d = POP;
            POP:       state_d = WAIT_ACC;
            WAIT_ACC:  state_d = WAIT_DONE;
            WAIT_DONE: if (!AEROUT_CTRL_BUSY) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_ext_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_ext_q <= last_ext_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers define validity.
    always_ff @(posedge CLK) begin
        if (push)
            mem_q[wr_ptr_q] <= push_addr;
    end

endmodule
